// File: rtl/shared_vc_allocator_if.sv
// Handshake and status bundle between an input port's shared-VC allocator and its neighbours:
// the bank allocators and the head-flit requester.
interface shared_vc_allocator_if #(
    parameter int unsigned num_vcs   = 10,
    parameter int unsigned num_ports = 5
);
    logic [num_ports*num_ports-1:0] memory_bank_grant_in;
    logic [num_ports-1:0]           bank_ready;
    logic                           alloc_req;
    logic                           alloc_gnt;
    logic [num_vcs-1:0]             alloc_vc;
    logic [num_vcs-1:0]             release_vc;
    logic [num_vcs-1:0]             allocated_shared_ivc;

    modport master (
        output memory_bank_grant_in,
        output bank_ready,
        output alloc_req,
        output release_vc,
        input  alloc_gnt,
        input  alloc_vc,
        input  allocated_shared_ivc
    );

    modport slave (
        input  memory_bank_grant_in,
        input  bank_ready,
        input  alloc_req,
        input  release_vc,
        output alloc_gnt,
        output alloc_vc,
        output allocated_shared_ivc
    );
endinterface

// File: rtl/shared_vc_allocator.sv
// Per-input-port allocator handing out free shared VCs from banks owned by this port.
// Round-robin selection, with a grant pulse followed by a hold cycle so the requester can drop its request.
module shared_vc_allocator #(
    parameter int unsigned num_vcs   = 10,
    parameter int unsigned num_ports = 5,
    parameter int unsigned port_id   = 0
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    shared_vc_allocator_if.slave   bus
);
    localparam int unsigned num_vcs_per_bank = num_vcs / num_ports;
    localparam int unsigned PtrW = (num_vcs > 1) ? $clog2(num_vcs) : 1;

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StGrant = 2'd1;
    localparam logic [1:0] StHold  = 2'd2;

    logic [1:0]         state_q, state_d;
    logic               gnt_q, gnt_d;
    logic [num_vcs-1:0] vc_q, vc_d;
    logic [num_vcs-1:0] alloc_q, alloc_d;
    logic [PtrW-1:0]    ptr_q, ptr_d;

    logic [num_vcs-1:0] elig;
    logic               found;
    logic [PtrW-1:0]    sel;
    int unsigned        idx;

    always_comb begin
        elig = '0;
        for (int unsigned v = 0; v < num_vcs; v++) begin
            elig[v] = bus.memory_bank_grant_in[(v / num_vcs_per_bank) * num_ports + port_id] &
                      bus.bank_ready[v / num_vcs_per_bank] & ~alloc_q[v];
        end
    end

    // First eligible VC at or after the pointer, wrapping at num_vcs-1.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        idx   = 0;
        for (int unsigned i = 0; i < num_vcs; i++) begin
            idx = 32'(ptr_q) + i;
            if (idx >= num_vcs) idx = idx - num_vcs;
            if (!found && elig[idx]) begin
                found = 1'b1;
                sel   = idx[PtrW-1:0];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = 1'b0;
        vc_d    = '0;
        ptr_d   = ptr_q;
        alloc_d = alloc_q & ~bus.release_vc;
        unique case (state_q)
            StIdle: begin
                if (bus.alloc_req && found) begin
                    gnt_d   = 1'b1;
                    vc_d    = num_vcs'(1) << sel;
                    alloc_d = alloc_d | (num_vcs'(1) << sel);
                    ptr_d   = (sel == PtrW'(num_vcs - 1)) ? '0 : sel + PtrW'(1);
                    state_d = StGrant;
                end
            end
            StGrant: state_d = StHold;
            StHold:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            gnt_q   <= 1'b0;
            vc_q    <= '0;
            alloc_q <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            vc_q    <= vc_d;
            alloc_q <= alloc_d;
            ptr_q   <= ptr_d;
        end
    end

    assign bus.alloc_gnt            = gnt_q;
    assign bus.alloc_vc             = vc_q;
    assign bus.allocated_shared_ivc = alloc_q;
endmodule

// File: tb/tb_shared_vc_allocator.sv
// Directed table-driven bench for shared_vc_allocator (5 ports, 10 VCs, port 0).
// VC k is bit k; bank b is bit b of bank masks and bank_ready.
module tb_shared_vc_allocator;
    localparam int unsigned NV = 10;
    localparam int unsigned NP = 5;

    typedef struct {
        logic [NP-1:0] own;
        logic [NP-1:0] ready;
        logic          req;
        logic [NV-1:0] rel;
        logic          exp_gnt;
        logic [NV-1:0] exp_vc;
        logic [NV-1:0] exp_alloc;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;
    vec_t vecs[$];

    shared_vc_allocator_if #(.num_vcs(NV), .num_ports(NP)) bus ();

    shared_vc_allocator #(.num_vcs(NV), .num_ports(NP), .port_id(0)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [NV-1:0] vc(input int k);
        return NV'(1) << k;
    endfunction

    // Owned banks grant port 0; the rest grant port 1.
    function automatic logic [NP*NP-1:0] own_map(input logic [NP-1:0] banks);
        logic [NP*NP-1:0] g = '0;
        for (int b = 0; b < NP; b++) g[b*NP + (banks[b] ? 0 : 1)] = 1'b1;
        return g;
    endfunction

    task automatic check(input string name, input logic [NV-1:0] got, input logic [NV-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input logic g, input logic [NV-1:0] v,
                             input logic [NV-1:0] a);
        check({tag, " gnt"}, NV'(bus.alloc_gnt), NV'(g));
        check({tag, " vc"}, bus.alloc_vc, v);
        check({tag, " alloc"}, bus.allocated_shared_ivc, a);
    endtask

    task automatic add(input logic [NP-1:0] own, input logic [NP-1:0] ready, input logic req,
                       input logic [NV-1:0] rel, input logic g, input logic [NV-1:0] v,
                       input logic [NV-1:0] a);
        vec_t r;
        r.own = own; r.ready = ready; r.req = req; r.rel = rel;
        r.exp_gnt = g; r.exp_vc = v; r.exp_alloc = a;
        vecs.push_back(r);
    endtask

    initial begin
        logic [NP-1:0] b0, b02, b2, rall, rnb0;
        b0 = 5'b00001; b02 = 5'b00101; b2 = 5'b00100; rall = 5'b11111; rnb0 = 5'b11110;

        // No request, then two grants from bank 0.
        add(b0, rall, 0, '0, 0, '0, '0);
        add(b0, rall, 0, '0, 0, '0, '0);
        add(b0, rall, 1, '0, 1, vc(0), vc(0));
        add(b0, rall, 1, '0, 0, '0, vc(0));
        add(b0, rall, 0, '0, 0, '0, vc(0));
        add(b0, rall, 1, '0, 1, vc(1), vc(0) | vc(1));
        add(b0, rall, 1, '0, 0, '0, vc(0) | vc(1));
        add(b0, rall, 1, '0, 0, '0, vc(0) | vc(1));
        // Bank full: request starves.
        for (int i = 0; i < 10; i++) add(b0, rall, 1, '0, 0, '0, vc(0) | vc(1));
        add(b0, rall, 0, vc(0), 0, '0, vc(1));
        add(b0, rall, 1, '0, 1, vc(0), vc(0) | vc(1));
        add(b0, rall, 0, '0, 0, '0, vc(0) | vc(1));
        add(b0, rall, 0, '0, 0, '0, vc(0) | vc(1));
        // Bank 0 not ready: only bank 2 VCs.
        add(b02, rnb0, 0, vc(0) | vc(1), 0, '0, '0);
        add(b02, rnb0, 1, '0, 1, vc(4), vc(4));
        add(b02, rnb0, 1, '0, 0, '0, vc(4));
        add(b02, rnb0, 1, '0, 0, '0, vc(4));
        add(b02, rnb0, 1, '0, 1, vc(5), vc(4) | vc(5));
        add(b02, rnb0, 1, '0, 0, '0, vc(4) | vc(5));
        add(b02, rnb0, 1, '0, 0, '0, vc(4) | vc(5));
        for (int i = 0; i < 3; i++) add(b02, rnb0, 1, '0, 0, '0, vc(4) | vc(5));
        // Bank 2 ownership lost: allocated bits persist.
        add(b0, rnb0, 1, '0, 0, '0, vc(4) | vc(5));
        add(b0, rall, 0, vc(4) | vc(5), 0, '0, '0);
        add(b0, rall, 1, '0, 1, vc(0), vc(0));
        add(b0, rall, 1, '0, 0, '0, vc(0));
        add(b0, rall, 1, '0, 0, '0, vc(0));
        add(b0, rall, 1, '0, 1, vc(1), vc(0) | vc(1));
        add(b0, rall, 0, '0, 0, '0, vc(0) | vc(1));
        add(b0, rall, 0, '0, 0, '0, vc(0) | vc(1));
        // Release of VC1 alongside grant of VC4.
        add(b02, rall, 1, vc(1), 1, vc(4), vc(0) | vc(4));

        bus.memory_bank_grant_in = own_map(b0);
        bus.bank_ready = rall;
        bus.alloc_req = 1'b1;
        bus.release_vc = '0;
        #2 check_all("reset_t0", 0, '0, '0);
        repeat (2) @(posedge clk);
        #1 check_all("reset_held", 0, '0, '0);
        @(negedge clk);
        bus.alloc_req = 1'b0;
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            bus.memory_bank_grant_in = own_map(vecs[i].own);
            bus.bank_ready = vecs[i].ready;
            bus.alloc_req = vecs[i].req;
            bus.release_vc = vecs[i].rel;
            @(posedge clk);
            #1 check_all($sformatf("vec%0d", i), vecs[i].exp_gnt, vecs[i].exp_vc,
                         vecs[i].exp_alloc);
        end

        // Asynchronous reset while the grant pulse is high.
        #2 rst_n = 1'b0;
        #1 check_all("async_rst", 0, '0, '0);
        @(negedge clk);
        bus.memory_bank_grant_in = own_map(b2);
        bus.bank_ready = rall;
        bus.alloc_req = 1'b1;
        bus.release_vc = '0;
        rst_n = 1'b1;
        @(posedge clk);
        #1 check_all("post_rst_grant", 1, vc(4), vc(4));
        @(posedge clk);
        #1 check_all("post_rst_grant_end", 0, '0, vc(4));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/shared_vc_allocator.md
Name: shared_vc_allocator

Overview:
Per-input-port allocator for shared input VCs. It sits directly downstream of the per-bank memory bank allocators, one instance per input port. It consumes each bank's one-hot port grant and ready flag, and hands free shared VCs from banks currently owned by its port to head flits that found no private VC. It also produces this port's slice of allocated_ip_shared_ivc. The bank allocators use that slice to decide when a bank is idle and can be moved to another port.

Parameters:
num_vcs, 10, total shared VCs across all banks (bank b owns VCs b*num_vcs_per_bank .. b*num_vcs_per_bank+num_vcs_per_bank-1)
num_ports, 5, number of router ports; also the number of memory banks
port_id, 0, index of the input port this instance serves (0..num_ports-1)
num_vcs_per_bank, num_vcs/num_ports, derived localparam; num_vcs must be a multiple of num_ports

Ports:
clk  input  1  clock; all state updates on the rising edge
reset  input  1  asynchronous, active-low reset
memory_bank_grant_in  input  num_ports*num_ports  concatenated grant vectors; bits [b*num_ports +: num_ports] are bank b's one-hot grant; bit b*num_ports+port_id means bank b is owned by this port
bank_ready  input  num_ports  ready_for_allocation of each bank
alloc_req  input  1  request for one shared VC; held high until alloc_gnt is seen
alloc_gnt  output  1  one-cycle pulse; alloc_vc is valid while it is high
alloc_vc  output  num_vcs  one-hot index of the granted shared VC; zero when alloc_gnt=0
release_vc  input  num_vcs  per-VC release pulse, asserted when a tail flit has drained the VC
allocated_shared_ivc  output  num_vcs  registered mask of shared VCs held by this port

Behaviour:
- Reset (reset=0), effective immediately and asynchronously:
  - alloc_gnt=0, alloc_vc=0, allocated_shared_ivc=0.
  - Round-robin pointer=0, state=IDLE.
- Eligibility, combinational, for each VC v with bank b=v/num_vcs_per_bank:
  - elig[v] = memory_bank_grant_in[b*num_ports+port_id] & bank_ready[b] & ~allocated_shared_ivc[v].
- Selection:
  - Round-robin over elig, starting at the pointer and wrapping from num_vcs-1 to 0.
  - On each grant the pointer becomes (granted index+1) mod num_vcs.
- State machine, states IDLE, GRANT, HOLD:
  - IDLE: if alloc_req=1 and |elig, register the selected VC into alloc_vc, set alloc_gnt=1, set its allocated bit, update the pointer, and go to GRANT. Otherwise stay in IDLE; the request remains pending with no timeout.
  - GRANT: one cycle with alloc_gnt=1 and alloc_vc valid. Next cycle alloc_gnt=0, alloc_vc=0, go to HOLD.
  - HOLD: one cycle in which no grant is issued, so the requester can drop alloc_req. Then go to IDLE.
- Latency:
  - alloc_req high together with nonzero elig, sampled at edge N, gives alloc_gnt high from edge N to edge N+1.
  - Minimum spacing between grants is 3 cycles.
- allocated_shared_ivc:
  - Bit set on the grant edge.
  - Bit cleared on the edge after release_vc[v]=1 is sampled.
  - Release of a bit that is not allocated is ignored.
  - Release and grant of different VCs in the same cycle both take effect.
  - A same-VC conflict cannot occur, because only unallocated VCs are eligible.
- Bank grant lost while VCs are still allocated: allocated bits are kept; only new eligibility is affected.
- bank_ready[b]=0 blocks new grants from bank b only.
- Exactly one alloc_vc bit is set whenever alloc_gnt=1.
- Illegal state encodings return to IDLE with outputs cleared.
- Reset in any state, including GRANT, drops alloc_gnt immediately and discards the pending grant.

Test Plan:
- Common setup: num_ports=5, num_vcs=10, port_id=0.
- Reset with bank0 grant=10000 and bank_ready=11111: all outputs are 0. After release, nothing is granted until alloc_req is raised.
- Bank0 owned by port0 (all other banks grant elsewhere), alloc_req held: alloc_gnt pulses 1 cycle after the request with alloc_vc=1000000000 and allocated=1000000000. A second request gives alloc_vc=0100000000 and allocated=1100000000.
- Both bank0 VCs allocated, alloc_req high: no grant for 10 cycles. Pulse release_vc=1000000000: allocated becomes 0100000000, and the next grant is VC0 (wrapping from pointer 2).
- Bank0 and bank2 owned by port0, but bank_ready=01111: grants come only from VCs 4 and 5; VCs 0 and 1 are never granted.
- release_vc=0100000000 in the same cycle as the grant of VC4 (allocated was 1100000000): allocated becomes 1000100000.
- Drive reset=0 while alloc_gnt=1: alloc_gnt and allocated clear immediately (before the next clk edge). After release, the pointer is 0 and the first grant is the lowest eligible VC.
